mc_frame_avg: RTL and testbench

Monte-Carlo trial averager sitting directly downstream of the MC convolution core. It consumes the 256-sample complex output frames that MC streams out, one frame per Monte-Carlo trial. It accumulates them bin-by-bin over 2^LOG_TRIALS trials. On the last trial of each batch it streams out the per-bin mean frame.

---
 rtl/mc_frame_avg_if.sv | 28 ++
 rtl/mc_frame_avg.sv | 108 ++++++++++
 tb/tb_mc_frame_avg.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/mc_frame_avg_if.sv
// mc_frame_avg_if: sample stream between the MC convolution core and the
// Monte-Carlo frame averager.
//   in_valid, x_real, x_img      : complex Q1.15 input beat (producer -> averager)
//   out_valid, y_real, y_img     : registered per-bin mean (averager -> consumer)
//   frame_done                   : pulse with bin 255 of a mean frame
//   trial_cnt                    : completed trials in the current batch
// master: the side that drives samples and observes results.
// slave : the averager itself.
interface mc_frame_avg_if;
  logic               in_valid;
  logic signed [15:0] x_real;
  logic signed [15:0] x_img;
  logic               out_valid;
  logic signed [15:0] y_real;
  logic signed [15:0] y_img;
  logic               frame_done;
  logic [7:0]         trial_cnt;

  modport master (
    output in_valid, x_real, x_img,
    input  out_valid, y_real, y_img, frame_done, trial_cnt
  );

  modport slave (
    input  in_valid, x_real, x_img,
    output out_valid, y_real, y_img, frame_done, trial_cnt
  );
endinterface

// File: rtl/mc_frame_avg.sv
// mc_frame_avg: accumulates 256-bin complex frames over 2^LOG_TRIALS trials and
// streams out the per-bin mean on the last trial of each batch.
// Ports:
//   clk   : clock, all logic on posedge
//   rst_n : asynchronous active-low reset
//   clr   : synchronous batch abort, drops a same-cycle beat
//   bus   : mc_frame_avg_if.slave (input stream, mean stream, frame_done, trial_cnt)
module mc_frame_avg #(
  parameter int unsigned LOG_TRIALS = 3,
  localparam int unsigned ACC_W     = 16 + LOG_TRIALS
) (
  input logic            clk,
  input logic            rst_n,
  input logic            clr,
  mc_frame_avg_if.slave  bus
);

  localparam logic [7:0] LastTrial = 8'((1 << LOG_TRIALS) - 1);

  logic signed [ACC_W-1:0] r_acc_real [256];
  logic signed [ACC_W-1:0] r_acc_img  [256];
  logic [7:0]              r_bin_idx;
  logic [7:0]              r_trial_cnt;
  logic                    r_out_valid;
  logic signed [15:0]      r_y_real;
  logic signed [15:0]      r_y_img;
  logic                    r_frame_done;

  logic                    w_last_trial;
  logic                    w_last_bin;
  logic signed [ACC_W-1:0] w_x_real_ext;
  logic signed [ACC_W-1:0] w_x_img_ext;
  logic signed [ACC_W-1:0] w_sum_real;
  logic signed [ACC_W-1:0] w_sum_img;
  logic signed [ACC_W-1:0] w_mean_real;
  logic signed [ACC_W-1:0] w_mean_img;

  assign w_last_trial = (r_trial_cnt == LastTrial);
  assign w_last_bin   = (r_bin_idx == 8'd255);

  // Signed size cast sign-extends; also valid when LOG_TRIALS is 0.
  assign w_x_real_ext = ACC_W'(bus.x_real);
  assign w_x_img_ext  = ACC_W'(bus.x_img);

  assign w_sum_real = r_acc_real[r_bin_idx] + w_x_real_ext;
  assign w_sum_img  = r_acc_img[r_bin_idx] + w_x_img_ext;

  // Arithmetic shift floors toward -inf; ACC_W headroom keeps the mean in 16 bits.
  assign w_mean_real = w_sum_real >>> LOG_TRIALS;
  assign w_mean_img  = w_sum_img >>> LOG_TRIALS;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) begin
        r_acc_real[i] <= '0;
        r_acc_img[i]  <= '0;
      end
      r_bin_idx    <= '0;
      r_trial_cnt  <= '0;
      r_out_valid  <= 1'b0;
      r_y_real     <= '0;
      r_y_img      <= '0;
      r_frame_done <= 1'b0;
    end else if (clr) begin
      for (int i = 0; i < 256; i++) begin
        r_acc_real[i] <= '0;
        r_acc_img[i]  <= '0;
      end
      r_bin_idx    <= '0;
      r_trial_cnt  <= '0;
      r_out_valid  <= 1'b0;
      r_y_real     <= '0;
      r_y_img      <= '0;
      r_frame_done <= 1'b0;
    end else begin
      // Outputs read zero whenever no mean is being emitted.
      r_out_valid  <= 1'b0;
      r_y_real     <= '0;
      r_y_img      <= '0;
      r_frame_done <= 1'b0;
      if (bus.in_valid) begin
        r_bin_idx <= r_bin_idx + 8'd1;
        if (w_last_bin) begin
          r_trial_cnt <= w_last_trial ? 8'd0 : r_trial_cnt + 8'd1;
        end
        if (w_last_trial) begin
          // Zero on read-out so the next batch starts clean without a clear pass.
          r_acc_real[r_bin_idx] <= '0;
          r_acc_img[r_bin_idx]  <= '0;
          r_out_valid           <= 1'b1;
          r_y_real              <= w_mean_real[15:0];
          r_y_img               <= w_mean_img[15:0];
          r_frame_done          <= w_last_bin;
        end else begin
          r_acc_real[r_bin_idx] <= w_sum_real;
          r_acc_img[r_bin_idx]  <= w_sum_img;
        end
      end
    end
  end

  assign bus.out_valid  = r_out_valid;
  assign bus.y_real     = r_y_real;
  assign bus.y_img      = r_y_img;
  assign bus.frame_done = r_frame_done;
  assign bus.trial_cnt  = r_trial_cnt;

endmodule

// File: tb/tb_mc_frame_avg.sv
// tb_mc_frame_avg: directed self-checking bench for mc_frame_avg at
// LOG_TRIALS = 3, 2 and 8. The LOG_TRIALS=8 extremes batch runs in parallel
// with the other tests to keep the run short.
module tb_mc_frame_avg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst3_n, rst2_n, rst8_n;
  logic clr3, clr2, clr8;

  int n_checks = 0;
  int n_fail   = 0;

  mc_frame_avg_if bus3 ();
  mc_frame_avg_if bus2 ();
  mc_frame_avg_if bus8 ();

  mc_frame_avg #(.LOG_TRIALS(3)) u_dut3 (.clk(clk), .rst_n(rst3_n), .clr(clr3), .bus(bus3));
  mc_frame_avg #(.LOG_TRIALS(2)) u_dut2 (.clk(clk), .rst_n(rst2_n), .clr(clr2), .bus(bus2));
  mc_frame_avg #(.LOG_TRIALS(8)) u_dut8 (.clk(clk), .rst_n(rst8_n), .clr(clr8), .bus(bus8));

  task automatic check_eq(input string tag, input logic signed [31:0] obs,
                          input logic signed [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Each beat task drives one cycle and returns 1 time unit after the edge.
  task automatic beat3(input logic v, input int xr, input int xi);
    bus3.in_valid = v;
    bus3.x_real   = 16'(xr);
    bus3.x_img    = 16'(xi);
    @(posedge clk);
    #1;
  endtask

  task automatic beat2(input logic v, input int xr, input int xi);
    bus2.in_valid = v;
    bus2.x_real   = 16'(xr);
    bus2.x_img    = 16'(xi);
    @(posedge clk);
    #1;
  endtask

  task automatic beat8(input logic v, input int xr, input int xi);
    bus8.in_valid = v;
    bus8.x_real   = 16'(xr);
    bus8.x_img    = 16'(xi);
    @(posedge clk);
    #1;
  endtask

  task automatic check_out3(input string tag, input logic v, input int yr, input int yi);
    check_eq({tag, "_valid"}, bus3.out_valid, v);
    check_eq({tag, "_yre"}, bus3.y_real, yr);
    check_eq({tag, "_yim"}, bus3.y_img, yi);
  endtask

  task automatic check_out2(input string tag, input logic v, input int yr, input int yi);
    check_eq({tag, "_valid"}, bus2.out_valid, v);
    check_eq({tag, "_yre"}, bus2.y_real, yr);
    check_eq({tag, "_yim"}, bus2.y_img, yi);
  endtask

  function automatic int ramp(input int k);
    return k * 100 - 12800;
  endfunction

  initial begin
    rst3_n = 1'b0; rst2_n = 1'b0; rst8_n = 1'b0;
    clr3 = 1'b0; clr2 = 1'b0; clr8 = 1'b0;
    bus3.in_valid = 1'b0; bus3.x_real = '0; bus3.x_img = '0;
    bus2.in_valid = 1'b0; bus2.x_real = '0; bus2.x_img = '0;
    bus8.in_valid = 1'b0; bus8.x_real = '0; bus8.x_img = '0;
    #12;
    check_out3("rst3", 1'b0, 0, 0);
    check_eq("rst3_fd", bus3.frame_done, 0);
    check_eq("rst3_tc", bus3.trial_cnt, 0);
    check_out2("rst2", 1'b0, 0, 0);
    check_eq("rst8_valid", bus8.out_valid, 0);
    @(negedge clk);
    rst3_n = 1'b1; rst2_n = 1'b1; rst8_n = 1'b1;

    fork
      begin : l8_extremes
        for (int t = 0; t < 256; t++) begin
          for (int k = 0; k < 256; k++) begin
            beat8(1'b1, (k < 128) ? -32768 : 32767, (k < 128) ? 32767 : -32768);
            if (t == 255) begin
              check_eq("ext_valid", bus8.out_valid, 1);
              check_eq("ext_yre", bus8.y_real, (k < 128) ? -32768 : 32767);
              check_eq("ext_yim", bus8.y_img, (k < 128) ? 32767 : -32768);
              check_eq("ext_fd", bus8.frame_done, (k == 255));
            end else if (k == 255) begin
              check_eq("ext_nov", bus8.out_valid, 0);
            end
            if (k == 255) check_eq("ext_tc", bus8.trial_cnt, (t + 1) % 256);
          end
        end
        beat8(1'b0, 0, 0);
      end
      begin : l3_l2_tests
        // Constant batch: outputs only during frame 8, one cycle after input.
        for (int t = 0; t < 8; t++) begin
          for (int k = 0; k < 256; k++) begin
            beat3(1'b1, 1000, -1000);
            if (t == 7) begin
              check_out3("const", 1'b1, 1000, -1000);
              check_eq("const_fd", bus3.frame_done, (k == 255));
            end else begin
              check_eq("const_nov", bus3.out_valid, 0);
            end
            if (k == 255) check_eq("const_tc", bus3.trial_cnt, (t + 1) % 8);
          end
        end
        beat3(1'b0, 0, 0);
        check_out3("const_idle", 1'b0, 0, 0);

        // Ramp batch with gaps in trial 3 and alternating valid in the final frame.
        for (int t = 0; t < 8; t++) begin
          for (int k = 0; k < 256; k++) begin
            beat3(1'b1, ramp(k), -ramp(k));
            if (t == 7) begin
              check_out3("gap_on", 1'b1, ramp(k), -ramp(k));
              check_eq("gap_fd", bus3.frame_done, (k == 255));
            end
            if (t == 7 || (t == 3 && k % 3 == 0)) begin
              beat3(1'b0, 7777, 7777);
              check_out3("gap_off", 1'b0, 0, 0);
              check_eq("gap_off_fd", bus3.frame_done, 0);
            end
          end
        end
        check_eq("gap_tc", bus3.trial_cnt, 0);

        // clr at bin 100 of trial 2 with a live beat, then a fresh batch of 500.
        for (int t = 0; t < 2; t++) begin
          for (int k = 0; k < 256; k++) beat3(1'b1, 9999, 9999);
        end
        for (int k = 0; k < 100; k++) beat3(1'b1, 9999, 9999);
        check_eq("clr_pre_tc", bus3.trial_cnt, 2);
        clr3 = 1'b1;
        beat3(1'b1, 9999, 9999);
        clr3 = 1'b0;
        check_eq("clr_tc", bus3.trial_cnt, 0);
        check_eq("clr_nov", bus3.out_valid, 0);
        for (int t = 0; t < 8; t++) begin
          for (int k = 0; k < 256; k++) begin
            beat3(1'b1, 500, 250);
            if (t == 7) begin
              check_out3("clr_batch", 1'b1, 500, 250);
              check_eq("clr_fd", bus3.frame_done, (k == 255));
            end
          end
        end

        // Async reset mid-final-frame, then a clean batch of -7.
        for (int t = 0; t < 7; t++) begin
          for (int k = 0; k < 256; k++) beat3(1'b1, 3000, -3000);
        end
        for (int k = 0; k < 50; k++) beat3(1'b1, 3000, -3000);
        check_out3("prerst", 1'b1, 3000, -3000);
        bus3.in_valid = 1'b0;
        #1;
        rst3_n = 1'b0;
        #1;
        check_out3("arst", 1'b0, 0, 0);
        check_eq("arst_tc", bus3.trial_cnt, 0);
        @(negedge clk);
        rst3_n = 1'b1;
        for (int t = 0; t < 8; t++) begin
          for (int k = 0; k < 256; k++) begin
            beat3(1'b1, -7, 7);
            if (t == 7) begin
              check_out3("post_rst", 1'b1, -7, 7);
              check_eq("post_rst_fd", bus3.frame_done, (k == 255));
            end
          end
        end
        beat3(1'b0, 0, 0);

        // LOG_TRIALS=2: real mean floors 1.5 -> k+1, imag exact -k.
        for (int j = 0; j < 4; j++) begin
          for (int k = 0; k < 256; k++) begin
            beat2(1'b1, k + j, -k);
            if (j == 3) begin
              check_out2("ramp2", 1'b1, k + 1, -k);
              check_eq("ramp2_fd", bus2.frame_done, (k == 255));
            end else if (k == 255) begin
              check_eq("ramp2_nov", bus2.out_valid, 0);
            end
          end
        end
        check_eq("ramp2_tc", bus2.trial_cnt, 0);
        // All-zero batch proves the read-out cleared every bin.
        for (int j = 0; j < 4; j++) begin
          for (int k = 0; k < 256; k++) begin
            beat2(1'b1, 0, 0);
            if (j == 3) check_out2("zero2", 1'b1, 0, 0);
          end
        end
        // Negative means floor toward -inf: -2/4 -> -1, -3/4 -> -1.
        for (int j = 0; j < 4; j++) begin
          for (int k = 0; k < 256; k++) begin
            beat2(1'b1, (j < 2) ? -1 : 0, (j == 0) ? -3 : 0);
            if (j == 3) check_out2("floor2", 1'b1, -1, -1);
          end
        end
        beat2(1'b0, 0, 0);
        check_out2("idle2", 1'b0, 0, 0);
      end
    join

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
